// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    localparam int N_REQ_DEF   = 4;
    localparam int TIMEOUT_DEF = 5000;

    // Width of the WAIT-state watchdog counter.
    localparam int WD_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req_i searching
// upward from last_grant_i+1 (mod N_REQ).
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: req_i (request vector), last_grant_i (previous winner),
//        grant_o (winner index, valid when any_valid_o), any_valid_o.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] last_grant_i,
    output logic [$clog2(N_REQ)-1:0] grant_o,
    output logic                     any_valid_o
);

    localparam int IW = $clog2(N_REQ);

    int   cand;
    logic found;

    // Walk the N_REQ candidates in priority order; the first hit wins.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_grant_i) + k) % N_REQ;
            if (!found && req_i[IW'(cand)]) begin
                found   = 1'b1;
                grant_o = IW'(cand);
            end
        end
    end

    assign any_valid_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte sources.
// Latency: grant + tx_req_o one cycle after req_valid is seen in IDLE; done one
// cycle after tx_ready_i in WAIT. Backpressure: one frame in flight; requests
// are only sampled in IDLE, so pending requesters simply hold req_valid.
// Ports: clk, reset (sync, active-high); req_valid/req_data/req_ack per
// requester; tx_req_o/tx_data_o/tx_ready_i to the UART; busy, done, timeout.
// Optional macro UART_ARB_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYCLES.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ          = N_REQ_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0][7:0] req_data,
    output logic [N_REQ-1:0]      req_ack,
    output logic                  tx_req_o,
    output logic [7:0]            tx_data_o,
    input  logic                  tx_ready_i,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t       state_q, state_d;
    logic             tx_req_q, tx_req_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [IW-1:0]    last_grant_q, last_grant_d;

    logic [IW-1:0]    pick_idx;
    logic             any_valid;

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    logic [WD_W-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
`endif

    rr_pick #(
        .N_REQ(N_REQ)
    ) u_rr_pick (
        .req_i       (req_valid),
        .last_grant_i(last_grant_q),
        .grant_o     (pick_idx),
        .any_valid_o (any_valid)
    );

    always_comb begin
        state_d      = state_q;
        tx_req_d     = 1'b0;
        tx_data_d    = tx_data_q;
        ack_d        = '0;
        done_d       = 1'b0;
        last_grant_d = last_grant_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        timeout_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d          = SEND;
                    tx_req_d         = 1'b1;
                    ack_d[pick_idx]  = 1'b1;
                    tx_data_d        = req_data[pick_idx];
                    last_grant_d     = pick_idx;
                end
            end
            SEND: begin
                // tx_req drops here, guaranteeing a low cycle before the next frame.
                state_d = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                // A frame-end pulse on the expiry cycle takes precedence.
                if (tx_ready_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == WD_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + WD_ONE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tx_req_q     <= 1'b0;
            tx_data_q    <= 8'h00;
            ack_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            last_grant_q <= IW'(N_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tx_req_q     <= tx_req_d;
            tx_data_q    <= tx_data_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            last_grant_q <= last_grant_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign tx_req_o  = tx_req_q;
    assign tx_data_o = tx_data_q;
    assign req_ack   = ack_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural UART and
// round-robin reference model.
// Latency/backpressure: n/a (testbench).
module tb_uart_tx_arbiter;

    localparam int NR       = 4;
    localparam int TO       = 50;
    localparam int BIT_CLKS = 434;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0][7:0] req_data;
    logic [NR-1:0]   req_ack;
    logic            tx_req_o;
    logic [7:0]      tx_data_o;
    logic            tx_ready_i;
    logic            busy, done, timeout;

    logic tb_ready   = 1'b0;
    logic uart_en    = 1'b0;
    logic uart_ready = 1'b0;
    logic tx_line    = 1'b1;

    assign tx_ready_i = tb_ready | uart_ready;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ(NR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .tx_req_o  (tx_req_o),
        .tx_data_o (tx_data_o),
        .tx_ready_i(tx_ready_i),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout)
    );

    // Behavioural UART: start bit, 8 data bits LSB first, stop bit, then a
    // one-cycle frame-end pulse.
    logic       u_prev   = 1'b0;
    logic       u_active = 1'b0;
    logic [9:0] u_frame  = '1;
    int         u_bit    = 0;
    int         u_clk    = 0;

    always @(posedge clk) begin
        uart_ready <= 1'b0;
        u_prev     <= tx_req_o;
        if (u_active) begin
            if (u_clk == BIT_CLKS - 1) begin
                u_clk <= 0;
                if (u_bit == 9) begin
                    u_active   <= 1'b0;
                    tx_line    <= 1'b1;
                    uart_ready <= 1'b1;
                end else begin
                    u_bit   <= u_bit + 1;
                    tx_line <= u_frame[u_bit + 1];
                end
            end else begin
                u_clk <= u_clk + 1;
            end
        end else if (uart_en && tx_req_o && !u_prev) begin
            u_active <= 1'b1;
            u_frame  <= {1'b1, tx_data_o, 1'b0};
            u_bit    <= 0;
            u_clk    <= 0;
            tx_line  <= 1'b0;
        end
    end

    // tx_req_o pulse monitor: rising edges and longest high run.
    logic m_prev = 1'b0;
    int   rises  = 0;
    int   hi_run = 0;
    int   max_hi = 0;
    always @(posedge clk) begin
        if (tx_req_o && !m_prev) rises = rises + 1;
        if (tx_req_o) hi_run = hi_run + 1;
        else          hi_run = 0;
        if (hi_run > max_hi) max_hi = hi_run;
        m_prev = tx_req_o;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int last_m  = NR - 1;   // reference model's last grant

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference round-robin: scan requesters cyclically after the last winner.
    function automatic int rr_ref(input logic [NR-1:0] mask, input int last);
        int order[$];
        for (int k = 1; k <= NR; k++) order.push_back((last + k) % NR);
        foreach (order[i]) if (mask[order[i]]) return order[i];
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; req_data = '0; tb_ready = 1'b0;
        repeat (3) step();
        n_tests++;
        if ({tx_req_o, req_ack} !== 5'b0) begin
            n_fail++; $display("FAIL reset_req: got %b required 00000", {tx_req_o, req_ack});
        end
        n_tests++;
        if (tx_data_o !== 8'h00) begin
            n_fail++; $display("FAIL reset_data: got %h required 00", tx_data_o);
        end
        n_tests++;
        if ({busy, done, timeout} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b required 000", {busy, done, timeout});
        end
        reset = 1'b0;
        last_m = NR - 1;
        step();
    endtask

    task automatic test_single_byte();
        req_data[0] = 8'hA5;
        req_valid   = 4'b0001;
        step();
        n_tests++;
        if ({req_ack, tx_req_o} !== {4'b0001, 1'b1}) begin
            n_fail++; $display("FAIL single_grant: got %b required 00011", {req_ack, tx_req_o});
        end
        n_tests++;
        if (tx_data_o !== 8'hA5) begin
            n_fail++; $display("FAIL single_data: got %h required a5", tx_data_o);
        end
        last_m    = 0;
        req_valid = '0;
        step();
        n_tests++;
        if ({tx_req_o, req_ack, busy} !== 6'b000001) begin
            n_fail++; $display("FAIL single_send_end: got %b required 000001", {tx_req_o, req_ack, busy});
        end
        repeat (5) step();
        tb_ready = 1'b1;
        step();
        tb_ready = 1'b0;
        n_tests++;
        if ({done, busy} !== 2'b10) begin
            n_fail++; $display("FAIL single_done: got %b required 10", {done, busy});
        end
        step();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL single_done_pulse: got %b required 0", done);
        end
    endtask

    task automatic test_idle_ready();
        req_valid = '0;
        tb_ready  = 1'b1;
        step();
        tb_ready  = 1'b0;
        n_tests++;
        if ({done, busy} !== 2'b00) begin
            n_fail++; $display("FAIL idle_ready: got %b required 00", {done, busy});
        end
        step();
        n_tests++;
        if ({tx_req_o, done, busy} !== 3'b000) begin
            n_fail++; $display("FAIL idle_stay: got %b required 000", {tx_req_o, done, busy});
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] mask;
        logic [NR-1:0] exp_ack;
        logic [7:0]    exp_dat;
        int            g;
        reset = 1'b1;
        step();
        reset  = 1'b0;
        last_m = NR - 1;
        mask   = '1;
        for (int i = 0; i < NR; i++) req_data[i] = 8'($urandom);
        req_valid = mask;
        for (int r = 0; r < 17; r++) begin
            g       = rr_ref(mask, last_m);
            exp_ack = 4'b0001 << g;
            exp_dat = req_data[g];
            step();
            n_tests++;
            if ({req_ack, tx_req_o} !== {exp_ack, 1'b1}) begin
                n_fail++; $display("FAIL rr_grant r=%0d: got %b required %b", r, {req_ack, tx_req_o}, {exp_ack, 1'b1});
            end
            n_tests++;
            if (tx_data_o !== exp_dat) begin
                n_fail++; $display("FAIL rr_data r=%0d: got %h required %h", r, tx_data_o, exp_dat);
            end
            last_m = g;
            step();
            n_tests++;
            if ({tx_req_o, req_ack, busy} !== 6'b000001) begin
                n_fail++; $display("FAIL rr_wait r=%0d: got %b required 000001", r, {tx_req_o, req_ack, busy});
            end
            repeat (18) step();
            n_tests++;
            if (tx_data_o !== exp_dat) begin
                n_fail++; $display("FAIL rr_hold r=%0d: got %h required %h", r, tx_data_o, exp_dat);
            end
            tb_ready = 1'b1;
            step();
            tb_ready = 1'b0;
            n_tests++;
            if ({done, busy, req_ack} !== 6'b100000) begin
                n_fail++; $display("FAIL rr_done r=%0d: got %b required 100000", r, {done, busy, req_ack});
            end
            if (r >= 4) mask = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) req_data[i] = 8'($urandom);
            req_valid = mask;
        end
        req_valid = '0;
        step();
        n_tests++;
        if ({req_ack, tx_req_o, done} !== 6'b0) begin
            n_fail++; $display("FAIL rr_quiet: got %b required 000000", {req_ack, tx_req_o, done});
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [NR-1:0] exp_ack;
        req_data[2] = 8'($urandom);
        req_valid   = 4'b0100;
        exp_ack     = 4'b0001 << rr_ref(4'b0100, last_m);
        step();
        n_tests++;
        if (req_ack !== exp_ack) begin
            n_fail++; $display("FAIL rst_wait_grant: got %b required %b", req_ack, exp_ack);
        end
        last_m    = 2;
        req_valid = '0;
        repeat (101) step();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_wait_busy: got %b required 1", busy);
        end
        reset = 1'b1;
        step();
        n_tests++;
        if ({busy, tx_req_o, tx_data_o, done} !== 11'b0) begin
            n_fail++; $display("FAIL rst_wait_clear: got %b required 0", {busy, tx_req_o, tx_data_o, done});
        end
        reset    = 1'b0;
        last_m   = NR - 1;
        tb_ready = 1'b1;
        step();
        tb_ready = 1'b0;
        n_tests++;
        if ({done, busy} !== 2'b00) begin
            n_fail++; $display("FAIL rst_late_ready: got %b required 00", {done, busy});
        end
        req_valid = 4'b1111;
        exp_ack   = 4'b0001 << rr_ref(4'b1111, last_m);
        step();
        n_tests++;
        if (req_ack !== exp_ack) begin
            n_fail++; $display("FAIL rst_next_grant: got %b required %b", req_ack, exp_ack);
        end
        last_m    = 0;
        req_valid = '0;
        step();
        tb_ready = 1'b1;
        step();
        tb_ready = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        logic [NR-1:0] exp_ack;
        req_valid = 4'b1000;
        exp_ack   = 4'b0001 << rr_ref(4'b1000, last_m);
        step();
        n_tests++;
        if (req_ack !== exp_ack) begin
            n_fail++; $display("FAIL to_grant: got %b required %b", req_ack, exp_ack);
        end
        last_m    = 3;
        req_valid = '0;
        step();   // WAIT entry edge just passed
`ifdef UART_ARB_TIMEOUT_EN
        begin
            int fire_at;
            int pulses;
            fire_at = -1;
            pulses  = 0;
            for (int k = 1; k <= TO + 10; k++) begin
                step();
                if (timeout === 1'b1) begin
                    pulses++;
                    if (fire_at < 0) fire_at = k;
                end
            end
            n_tests++;
            if (fire_at !== TO) begin
                n_fail++; $display("FAIL to_fire_cycle: got %0d required %0d", fire_at, TO);
            end
            n_tests++;
            if (pulses !== 1) begin
                n_fail++; $display("FAIL to_pulse_len: got %0d required 1", pulses);
            end
            n_tests++;
            if ({busy, done} !== 2'b00) begin
                n_fail++; $display("FAIL to_idle: got %b required 00", {busy, done});
            end
            req_valid = 4'b0001;
            step();
            last_m    = 0;
            req_valid = '0;
            step();
            repeat (TO - 1) step();
            tb_ready = 1'b1;
            step();
            tb_ready = 1'b0;
            n_tests++;
            if ({done, timeout} !== 2'b10) begin
                n_fail++; $display("FAIL to_ready_wins: got %b required 10", {done, timeout});
            end
        end
`else
        begin
            logic ok;
            ok = 1'b1;
            for (int k = 0; k < 6 * TO; k++) begin
                step();
                if (busy !== 1'b1 || timeout !== 1'b0) ok = 1'b0;
            end
            n_tests++;
            if (ok !== 1'b1) begin
                n_fail++; $display("FAIL no_to_hold: busy/timeout left 1/0 (ok=%b required 1)", ok);
            end
            tb_ready = 1'b1;
            step();
            tb_ready = 1'b0;
            n_tests++;
            if ({done, busy} !== 2'b10) begin
                n_fail++; $display("FAIL no_to_done: got %b required 10", {done, busy});
            end
        end
`endif
        step();
    endtask

    task automatic test_stream();
        logic [7:0] exp_b[2];
        logic [7:0] got;
        logic       found;
        int         r0;
        exp_b[0] = 8'h3C;
        exp_b[1] = 8'hC3;
        r0       = rises;
        uart_en  = 1'b1;
        req_data[2] = exp_b[0];
        req_valid   = 4'b0100;
        for (int f = 0; f < 2; f++) begin
            found = 1'b0;
            for (int t = 0; t < 6000 && !found; t++) begin
                step();
                if (req_ack !== 4'b0000) found = 1'b1;
            end
            n_tests++;
            if (req_ack !== 4'b0100) begin
                n_fail++; $display("FAIL stream_ack f=%0d: got %b required 0100", f, req_ack);
            end
            if (f == 0) req_data[2] = exp_b[1];
            else        req_valid   = '0;
            found = 1'b0;
            for (int t = 0; t < 10 && !found; t++) begin
                step();
                if (tx_line === 1'b0) found = 1'b1;
            end
            repeat (BIT_CLKS / 2) step();
            n_tests++;
            if (tx_line !== 1'b0) begin
                n_fail++; $display("FAIL stream_start f=%0d: got %b required 0", f, tx_line);
            end
            for (int b = 0; b < 8; b++) begin
                repeat (BIT_CLKS) step();
                got[b] = tx_line;
            end
            repeat (BIT_CLKS) step();
            n_tests++;
            if (tx_line !== 1'b1) begin
                n_fail++; $display("FAIL stream_stop f=%0d: got %b required 1", f, tx_line);
            end
            n_tests++;
            if (got !== exp_b[f]) begin
                n_fail++; $display("FAIL stream_byte f=%0d: got %h required %h", f, got, exp_b[f]);
            end
        end
        found = 1'b0;
        for (int t = 0; t < 400 && !found; t++) begin
            step();
            if (done === 1'b1) found = 1'b1;
        end
        n_tests++;
        if (found !== 1'b1) begin
            n_fail++; $display("FAIL stream_done: got %b required 1", found);
        end
        n_tests++;
        if (rises - r0 !== 2) begin
            n_fail++; $display("FAIL stream_rises: got %0d required 2", rises - r0);
        end
        n_tests++;
        if (max_hi !== 1) begin
            n_fail++; $display("FAIL stream_req_width: got %0d required 1", max_hi);
        end
        uart_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_idle_ready();
        test_round_robin();
        test_reset_mid_wait();
        test_timeout();
        test_stream();
        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

endmodule
